// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding,
// default frame geometry and repeat-count width.
package seq_gen_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GAP   = 2;
    localparam int REPS_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// Working shift register for the generator. Holds the bits still to be sent
// after the one currently on DOUT; the next bit to send is always the MSB.
module seq_gen_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Load has priority over shift; otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a latched WIDTH-bit pattern MSB first,
// REPS times (0 = until STOP) with GAP idle-low cycles between frames.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [WIDTH-1:0]  PDATA,
    input  logic [REPS_W-1:0] REPS,
    output logic              DOUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [REPS_W-1:0] frm_cnt;
    logic [REPS_W-1:0] reps_l;
    logic [3:0]        gap_cnt;
    logic [WIDTH-1:0]  pat;

    logic             accept;
    logic             end_frame;
    logic             last_frame;
    logic             gap_end;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;
    logic [WIDTH-1:0] sr_din;

    // Frame/gap boundary decode and shift-register control. The shift
    // register is loaded with the pattern minus its MSB, because the MSB goes
    // straight to DOUT on the same edge.
    always_comb begin
        accept     = (state == ST_IDLE) && START;
        end_frame  = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
        last_frame = (reps_l != '0) && ((frm_cnt + 4'd1) == reps_l);
        gap_end    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
        sr_load    = accept ||
                     (!STOP && ((end_frame && !last_frame && (GAP == 0)) || gap_end));
        sr_shift   = (state == ST_SHIFT) && !end_frame && !STOP;
        sr_din     = accept ? {PDATA[WIDTH-2:0], 1'b0} : {pat[WIDTH-2:0], 1'b0};
    end

    seq_gen_shreg #(.WIDTH(WIDTH)) u_shreg (
        .CLK   (CLK),
        .RST   (RST),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (sr_msb)
    );

    // Control FSM with registered DOUT/BUSY/DONE; reset beats STOP beats progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            DOUT    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            bit_cnt <= '0;
            frm_cnt <= '0;
            gap_cnt <= '0;
            reps_l  <= '0;
            pat     <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        pat     <= PDATA;
                        reps_l  <= REPS;
                        bit_cnt <= '0;
                        frm_cnt <= '0;
                        DOUT    <= PDATA[WIDTH-1];
                        BUSY    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        DOUT  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (!end_frame) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        DOUT    <= sr_msb;
                    end else if (last_frame) begin
                        state <= ST_IDLE;
                        DOUT  <= 1'b0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        // Free-running runs never advance the frame count,
                        // so it cannot wrap into a false termination.
                        if (reps_l != '0) begin
                            frm_cnt <= frm_cnt + 4'd1;
                        end
                        bit_cnt <= '0;
                        if (GAP == 0) begin
                            DOUT <= pat[WIDTH-1];
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            DOUT    <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        DOUT  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (gap_end) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        DOUT    <= pat[WIDTH-1];
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    DOUT  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a GAP=2 and a GAP=0 build driven by the same stimulus,
// each checked every cycle against a stream-position model, plus directed
// scenarios with hand-computed expectations.
module tb_seq_gen;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          STOP;
    logic [W-1:0]  PDATA;
    logic [3:0]    REPS;
    logic          dout_a, busy_a, done_a;
    logic          dout_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    seq_gen #(.WIDTH(W), .GAP(2)) dut_a (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PDATA(PDATA),
        .REPS(REPS), .DOUT(dout_a), .BUSY(busy_a), .DONE(done_a)
    );

    seq_gen #(.WIDTH(W), .GAP(0)) dut_b (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PDATA(PDATA),
        .REPS(REPS), .DOUT(dout_b), .BUSY(busy_b), .DONE(done_b)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // Reference model: a run is a stream of busy cycles indexed by k. Frame
    // period is W+gap; positions below W carry pattern bits MSB first, the rest
    // are zeros. A finite run lasts reps*W + (reps-1)*gap busy cycles,
    // followed by one DONE cycle.
    int          gp [2] = '{2, 0};
    bit          mbusy [2];
    int          mk [2];
    logic [W-1:0] mpat [2];
    int          mreps [2];
    logic [2:0]  expv [2];
    bit          chk_en = 1'b0;

    function automatic logic mbit(int i, int k);
        int p;
        p = k % (W + gp[i]);
        if (p < W) return mpat[i][W-1-p];
        return 1'b0;
    endfunction

    // Advance the model on each rising edge using the inputs seen at that edge.
    always @(posedge CLK) begin
        logic d, b, dn;
        for (int i = 0; i < 2; i++) begin
            d = 1'b0; b = 1'b0; dn = 1'b0;
            if (RST) begin
                mbusy[i] = 1'b0;
            end else if (mbusy[i]) begin
                if (STOP) begin
                    mbusy[i] = 1'b0;
                end else begin
                    mk[i] = mk[i] + 1;
                    if (mreps[i] != 0 && mk[i] == mreps[i] * W + (mreps[i] - 1) * gp[i]) begin
                        mbusy[i] = 1'b0;
                        dn = 1'b1;
                    end else begin
                        b = 1'b1;
                        d = mbit(i, mk[i]);
                    end
                end
            end else if (START) begin
                mbusy[i] = 1'b1;
                mk[i]    = 0;
                mpat[i]  = PDATA;
                mreps[i] = int'(REPS);
                b = 1'b1;
                d = mbit(i, 0);
            end
            expv[i] = {d, b, dn};
        end
        chk_en = 1'b1;
    end

    // Compare both builds against the model every cycle, mid-period.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("stream_gap2", {29'd0, dout_a, busy_a, done_a}, {29'd0, expv[0]});
            cmp("stream_gap0", {29'd0, dout_b, busy_b, done_b}, {29'd0, expv[1]});
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        cmp("idle_timeout", {30'd0, busy_a, busy_b}, 32'd0);
        @(negedge CLK);
    endtask

    task automatic go(input logic [W-1:0] pd, input logic [3:0] rp);
        PDATA = pd; REPS = rp; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        logic [W-1:0] cap;
        int run, maxrun, nb, nbb, nd, k;

        RST = 1'b1; START = 1'b0; STOP = 1'b0; PDATA = '0; REPS = '0;
        repeat (2) @(negedge CLK);
        cmp("reset_a", {29'd0, dout_a, busy_a, done_a}, 32'd0);
        cmp("reset_b", {29'd0, dout_b, busy_b, done_b}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Single frame 07FE: ten-ones run, then a single DONE cycle.
        go(16'h07FE, 4'd1);
        cap = '0; run = 0; maxrun = 0;
        for (int i = 0; i < W; i++) begin
            cap = {cap[W-2:0], dout_a};
            run = dout_a ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            @(negedge CLK);
        end
        cmp("frame_07fe", {16'd0, cap}, 32'h07FE);
        cmp("ones_run", maxrun, 10);
        cmp("done_07fe", {30'd0, busy_a, done_a}, 32'd1);
        @(negedge CLK);
        cmp("done_pulse_len", {31'd0, done_a}, 32'd0);
        wait_idle();

        // Three frames of A5A5: 52 busy cycles with gap 2, 48 with gap 0.
        go(16'hA5A5, 4'd3);
        nb = 0; nbb = 0; nd = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy_a) nb++;
            if (busy_b) nbb++;
            if (done_a) nd++;
            @(negedge CLK);
        end
        cmp("busy_len_gap2", nb, 52);
        cmp("busy_len_gap0", nbb, 48);
        cmp("done_count", nd, 1);
        wait_idle();

        // Gap-0 build, two frames of FFFF: 32 ones then DONE.
        go(16'hFFFF, 4'd2);
        k = 0;
        while (dout_b && k < 40) begin
            k++;
            @(negedge CLK);
        end
        cmp("ones_gap0", k, 32);
        cmp("done_gap0", {31'd0, done_b}, 32'd1);
        wait_idle();

        // Free-running 8001 for well over 20 frames, then STOP mid-frame.
        go(16'h8001, 4'd0);
        nd = 0;
        repeat (25 * 18 + 7) begin
            if (done_a || done_b) nd++;
            @(negedge CLK);
        end
        cmp("free_no_done", nd, 0);
        cmp("free_busy", {30'd0, busy_a, busy_b}, 32'd3);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        cmp("stop_outputs", {26'd0, dout_a, busy_a, done_a, dout_b, busy_b, done_b}, 32'd0);
        @(negedge CLK);
        cmp("stop_no_done", {30'd0, done_a, done_b}, 32'd0);

        // START while busy is ignored; reset mid-frame aborts silently.
        go(16'h1234, 4'd2);
        repeat (3) @(negedge CLK);
        go(16'hFFFF, 4'd1);
        PDATA = 16'h5555;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        cmp("rst_mid", {26'd0, dout_a, busy_a, done_a, dout_b, busy_b, done_b}, 32'd0);
        @(negedge CLK);
        cmp("rst_no_done", {30'd0, done_a, done_b}, 32'd0);

        // STOP coincident with the final bit wins over DONE.
        go(16'hF00F, 4'd1);
        repeat (15) @(negedge CLK);
        cmp("lsb_shown", {31'd0, dout_a}, 32'd1);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        cmp("stop_last_bit", {28'd0, busy_a, done_a, busy_b, done_b}, 32'd0);
        wait_idle();

        // START during the DONE cycle begins a new run immediately.
        go(16'h0001, 4'd1);
        k = 0;
        while (!done_a && k < 40) begin
            @(negedge CLK);
            k++;
        end
        cmp("done_seen", {31'd0, done_a}, 32'd1);
        go(16'h8000, 4'd1);
        cmp("back_to_back", {30'd0, dout_a, busy_a}, 32'd3);
        wait_idle();

        // START and STOP together in IDLE: START is taken.
        PDATA = 16'hC000; REPS = 4'd1; START = 1'b1; STOP = 1'b1;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        cmp("start_stop_idle", {30'd0, dout_a, busy_a}, 32'd3);
        wait_idle();

        // Randomized traffic, checked by the per-cycle model compare.
        repeat (3000) begin
            START = ($urandom_range(0, 7) == 0);
            STOP  = ($urandom_range(0, 39) == 0);
            RST   = ($urandom_range(0, 299) == 0);
            PDATA = W'($urandom);
            REPS  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            @(negedge CLK);
        end
        RST = 1'b0; START = 1'b0; STOP = 1'b0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
